mby_wm_egress_pkt_collector: RTL and testbench

//  Receive end of the white-model packet path. The push path injects packets into the DUT.

---
 rtl/mby_wm_egress_pkt_collector.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_mby_wm_egress_pkt_collector.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mby_wm_egress_pkt_collector.sv
// Egress packet collector: stores whole packets from one port stream and replays
// them as {port, len, data} records through a store-and-forward buffer.
module mby_wm_egress_pkt_collector #(
  parameter int unsigned BUF_WORDS     = 64,
  parameter int unsigned DESC_DEPTH    = 8,
  parameter int unsigned MAX_PKT_WORDS = 32,
  parameter int unsigned PORT_W        = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [2:0]        in_bcnt,
  input  logic [PORT_W-1:0] in_port,
  input  logic [63:0]       in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_data,
  output logic              out_sop,
  output logic              out_eop,
  output logic [2:0]        out_bcnt,
  output logic [PORT_W-1:0] out_port,
  output logic [15:0]       out_len,
  output logic              out_err,
  output logic [31:0]       pkt_cnt,
  output logic [15:0]       err_cnt
);

  localparam int unsigned AW = $clog2(BUF_WORDS);
  localparam int unsigned DW = $clog2(DESC_DEPTH);
  localparam int unsigned WW = $clog2(MAX_PKT_WORDS + 1);
  localparam logic [AW:0]   BUF_FULL  = (AW+1)'(BUF_WORDS);
  localparam logic [DW:0]   DESC_FULL = (DW+1)'(DESC_DEPTH);
  localparam logic [WW-1:0] MAX_W     = WW'(MAX_PKT_WORDS);

  typedef struct packed {
    logic [AW-1:0]     start;
    logic [WW-1:0]     words;
    logic [PORT_W-1:0] port;
    logic [15:0]       len;
    logic              err;
  } desc_t;

  typedef enum logic {W_IDLE, W_PKT}  wstate_t;
  typedef enum logic {R_IDLE, R_STRM} rstate_t;

  logic [63:0] mem [BUF_WORDS];
  desc_t       dfifo [DESC_DEPTH];

  wstate_t wstate, wnext;
  rstate_t rstate, rnext;

  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       used_words;
  logic [DW-1:0]     dwr, drd, fidx;
  logic [DW:0]       dcount;
  logic              desc_full;

  logic [AW-1:0]     cur_start, cur_start_n;
  logic [WW-1:0]     cur_words, cur_words_n;
  logic [15:0]       cur_len, cur_len_n;
  logic [PORT_W-1:0] cur_port, cur_port_n;
  logic              cur_err, cur_err_n;

  logic              acc, wr_en, commit, err_inc, ovf;
  logic [15:0]       blen, beat_len;
  desc_t             cdesc, sdesc, pend_desc, push_desc, fdesc;
  logic              pend, pend_set, push;

  logic [WW-1:0]     beat_idx, rec_words;
  logic              last_beat, ohs, load_first, load_next, pop;

  // A sop+eop beat that also closes an open packet needs two commits; the
  // second is parked in pend and in_ready is held low until it is pushed.
  assign desc_full = (dcount == DESC_FULL);
  assign in_ready  = !rst && !desc_full && (used_words < BUF_FULL) && !pend;
  assign acc       = in_valid && in_ready;
  assign blen      = 16'(in_bcnt) + 16'd1;
  assign beat_len  = in_eop ? blen : 16'd8;
  assign ovf       = (cur_words >= MAX_W);
  assign sdesc     = '{wr_ptr, WW'(1), in_port, blen, 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wstate <= W_IDLE;
    else     wstate <= wnext;
  end

  always_comb begin
    wnext       = wstate;
    wr_en       = 1'b0;
    commit      = 1'b0;
    err_inc     = 1'b0;
    pend_set    = 1'b0;
    cdesc       = '0;
    cur_start_n = cur_start;
    cur_words_n = cur_words;
    cur_len_n   = cur_len;
    cur_port_n  = cur_port;
    cur_err_n   = cur_err;
    if (acc) begin
      case (wstate)
        W_IDLE: begin
          if (!in_sop) begin
            err_inc = 1'b1;
          end else begin
            wr_en = 1'b1;
            if (in_eop) begin
              commit = 1'b1;
              cdesc  = sdesc;
            end else begin
              wnext       = W_PKT;
              cur_start_n = wr_ptr;
              cur_words_n = WW'(1);
              cur_len_n   = 16'd8;
              cur_port_n  = in_port;
              cur_err_n   = 1'b0;
            end
          end
        end
        W_PKT: begin
          if (in_sop) begin
            commit  = 1'b1;
            err_inc = 1'b1;
            cdesc   = '{cur_start, cur_words, cur_port, cur_len, 1'b1};
            wr_en   = 1'b1;
            if (in_eop) begin
              pend_set = 1'b1;
              wnext    = W_IDLE;
            end else begin
              cur_start_n = wr_ptr;
              cur_words_n = WW'(1);
              cur_len_n   = 16'd8;
              cur_port_n  = in_port;
              cur_err_n   = 1'b0;
            end
          end else begin
            if (!ovf) begin
              wr_en       = 1'b1;
              cur_words_n = cur_words + WW'(1);
              cur_len_n   = cur_len + beat_len;
            end
            cur_err_n = cur_err | ovf;
            if (in_eop) begin
              commit  = 1'b1;
              err_inc = cur_err_n;
              cdesc   = '{cur_start, cur_words_n, cur_port, cur_len_n, cur_err_n};
              wnext   = W_IDLE;
            end
          end
        end
        default: wnext = W_IDLE;
      endcase
    end
  end

  assign push      = commit || (pend && !desc_full);
  assign push_desc = commit ? cdesc : pend_desc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_start <= '0;
      cur_words <= '0;
      cur_len   <= '0;
      cur_port  <= '0;
      cur_err   <= 1'b0;
      pend      <= 1'b0;
      pend_desc <= '0;
      wr_ptr    <= '0;
      pkt_cnt   <= '0;
      err_cnt   <= '0;
    end else begin
      cur_start <= cur_start_n;
      cur_words <= cur_words_n;
      cur_len   <= cur_len_n;
      cur_port  <= cur_port_n;
      cur_err   <= cur_err_n;
      if (pend_set) begin
        pend      <= 1'b1;
        pend_desc <= sdesc;
      end else if (pend && !desc_full) begin
        pend <= 1'b0;
      end
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (push) pkt_cnt <= pkt_cnt + 32'd1;
      if (err_inc && (err_cnt != '1)) err_cnt <= err_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= in_data;
    if (push)  dfifo[dwr] <= push_desc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwr        <= '0;
      drd        <= '0;
      dcount     <= '0;
      used_words <= '0;
    end else begin
      if (push) dwr <= dwr + DW'(1);
      if (pop)  drd <= drd + DW'(1);
      case ({push, pop})
        2'b10:   dcount <= dcount + (DW+1)'(1);
        2'b01:   dcount <= dcount - (DW+1)'(1);
        default: dcount <= dcount;
      endcase
      case ({wr_en, ohs})
        2'b10:   used_words <= used_words + (AW+1)'(1);
        2'b01:   used_words <= used_words - (AW+1)'(1);
        default: used_words <= used_words;
      endcase
    end
  end

  // Read side: output registers are loaded from the buffer one cycle ahead.
  assign out_valid = (rstate == R_STRM);
  assign ohs       = out_valid && out_ready;
  assign last_beat = (beat_idx == rec_words - WW'(1));
  assign out_sop   = out_valid && (beat_idx == '0);
  assign out_eop   = out_valid && last_beat;
  assign out_bcnt  = out_eop ? (out_len[2:0] - 3'd1) : '0;
  assign fdesc     = dfifo[fidx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rstate <= R_IDLE;
    else     rstate <= rnext;
  end

  always_comb begin
    rnext      = rstate;
    load_first = 1'b0;
    load_next  = 1'b0;
    pop        = 1'b0;
    fidx       = drd;
    case (rstate)
      R_IDLE: begin
        if (dcount != '0) begin
          load_first = 1'b1;
          rnext      = R_STRM;
        end
      end
      R_STRM: begin
        if (out_ready) begin
          if (last_beat) begin
            pop = 1'b1;
            if (dcount >= (DW+1)'(2)) begin
              load_first = 1'b1;
              fidx       = drd + DW'(1);
            end else begin
              rnext = R_IDLE;
            end
          end else begin
            load_next = 1'b1;
          end
        end
      end
      default: rnext = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      beat_idx  <= '0;
      rec_words <= '0;
      out_data  <= '0;
      out_port  <= '0;
      out_len   <= '0;
      out_err   <= 1'b0;
    end else if (load_first) begin
      rd_ptr    <= fdesc.start;
      out_data  <= mem[fdesc.start];
      beat_idx  <= '0;
      rec_words <= fdesc.words;
      out_port  <= fdesc.port;
      out_len   <= fdesc.len;
      out_err   <= fdesc.err;
    end else if (load_next) begin
      rd_ptr   <= rd_ptr + AW'(1);
      out_data <= mem[rd_ptr + AW'(1)];
      beat_idx <= beat_idx + WW'(1);
    end
  end

endmodule

// File: tb/tb_mby_wm_egress_pkt_collector.sv
// Directed bench for mby_wm_egress_pkt_collector: packet vector table plus
// hand-written sequences for backpressure, protocol errors and reset.
module tb_mby_wm_egress_pkt_collector;

  localparam int unsigned PW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0, in_ready;
  logic          in_sop = 1'b0, in_eop = 1'b0;
  logic [2:0]    in_bcnt = '0;
  logic [PW-1:0] in_port = '0;
  logic [63:0]   in_data = '0;
  logic          out_valid, out_ready = 1'b0;
  logic [63:0]   out_data;
  logic          out_sop, out_eop, out_err;
  logic [2:0]    out_bcnt;
  logic [PW-1:0] out_port;
  logic [15:0]   out_len;
  logic [31:0]   pkt_cnt;
  logic [15:0]   err_cnt;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [31:0] exp_pkt = '0;
  logic [15:0] exp_err = '0;

  mby_wm_egress_pkt_collector #(
    .BUF_WORDS(64), .DESC_DEPTH(8), .MAX_PKT_WORDS(32), .PORT_W(PW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop), .in_eop(in_eop),
    .in_bcnt(in_bcnt), .in_port(in_port), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sop(out_sop), .out_eop(out_eop), .out_bcnt(out_bcnt),
    .out_port(out_port), .out_len(out_len), .out_err(out_err),
    .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned   nbeats;
    logic [PW-1:0] port;
    logic [2:0]    bcnt;
    int unsigned   exp_words;
    logic [15:0]   exp_len;
    logic          exp_err;
    logic [15:0]   exp_err_inc;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] dat(input logic [31:0] tag, input int unsigned i);
    return {tag, 32'hC0DE_0000 | 32'(i)};
  endfunction

  // Entered and left on a falling edge.
  task automatic send_beat(input logic sop, input logic eop, input logic [2:0] bcnt,
                           input logic [PW-1:0] port, input logic [63:0] data);
    bit done = 0;
    in_valid = 1'b1; in_sop = sop; in_eop = eop; in_bcnt = bcnt;
    in_port = port; in_data = data;
    for (int k = 0; k < 300 && !done; k++) begin
      if (in_ready) begin
        @(posedge clk);
        done = 1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!done) check("in_ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_pkt(input logic [31:0] tag, input int unsigned n, input logic [PW-1:0] port,
                          input logic [2:0] bcnt, input logic with_eop);
    for (int unsigned i = 0; i < n; i++) begin
      logic last;
      last = with_eop && (i == n - 1);
      // non-sop beats carry junk port and non-eop beats junk bcnt; both must be ignored
      send_beat(i == 0, last, last ? bcnt : 3'(i + 2), (i == 0) ? port : ~port, dat(tag, i));
    end
  endtask

  task automatic drain(input logic [31:0] tag, input int unsigned words, input logic [PW-1:0] port,
                       input logic [15:0] len, input logic err, output int unsigned waited);
    logic [2:0]  eb;
    logic [63:0] all1, mask;
    eb = 3'(len - 16'd1);
    all1 = '1;
    out_ready = 1'b1;
    waited = 0;
    while (!out_valid && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (!out_valid) begin
      check("out_valid_timeout", 64'd0, 64'd1);
      out_ready = 1'b0;
      return;
    end
    for (int unsigned i = 0; i < words; i++) begin
      logic last;
      last = (i == words - 1);
      mask = last ? ~(all1 << (8 * (int'(eb) + 1))) : all1;
      check("valid", out_valid, 1'b1);
      check("sop", out_sop, i == 0);
      check("eop", out_eop, last);
      check("port", out_port, port);
      check("len", out_len, len);
      check("err", out_err, err);
      check("bcnt", out_bcnt, last ? eb : 3'd0);
      check("data", out_data & mask, dat(tag, i) & mask);
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    int unsigned w;
    vecs[0] = '{8,  5'd3,  3'd7, 8,  16'd64,  1'b0, 16'd0};
    vecs[1] = '{8,  5'd9,  3'd4, 8,  16'd61,  1'b0, 16'd0};
    vecs[2] = '{40, 5'd17, 3'd7, 32, 16'd256, 1'b1, 16'd1};
    vecs[3] = '{1,  5'd31, 3'd0, 1,  16'd1,   1'b0, 16'd0};
    vecs[4] = '{32, 5'd12, 3'd2, 32, 16'd251, 1'b0, 16'd0};
    vecs[5] = '{33, 5'd1,  3'd7, 32, 16'd256, 1'b1, 16'd1};
    vecs[6] = '{3,  5'd0,  3'd5, 3,  16'd22,  1'b0, 16'd0};

    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_pkt_cnt", pkt_cnt, 32'd0);
    check("rst_err_cnt", err_cnt, 16'd0);
    check("rst_out_len", out_len, 16'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1'b1);

    for (int v = 0; v < 7; v++) begin
      send_pkt(32'h100 + 32'(v), vecs[v].nbeats, vecs[v].port, vecs[v].bcnt, 1'b1);
      exp_pkt = exp_pkt + 32'd1;
      exp_err = exp_err + vecs[v].exp_err_inc;
      check("vec_valid_lat0", out_valid, 1'b0);
      check("vec_pkt_cnt", pkt_cnt, exp_pkt);
      check("vec_err_cnt", err_cnt, exp_err);
      @(negedge clk);
      check("vec_valid_lat1", out_valid, 1'b1);
      drain(32'h100 + 32'(v), vecs[v].exp_words, vecs[v].port, vecs[v].exp_len, vecs[v].exp_err, w);
      check("vec_drained", out_valid, 1'b0);
    end

    // back-to-back records: second sop on the cycle after first eop
    send_pkt(32'h200, 2, 5'd7, 3'd7, 1'b1);
    send_pkt(32'h201, 3, 5'd8, 3'd1, 1'b1);
    exp_pkt = exp_pkt + 32'd2;
    drain(32'h200, 2, 5'd7, 16'd16, 1'b0, w);
    drain(32'h201, 3, 5'd8, 16'd18, 1'b0, w);
    check("b2b_gap", w, 0);

    // buffer full under backpressure
    send_pkt(32'h300, 32, 5'd3, 3'd7, 1'b1);
    send_pkt(32'h301, 32, 5'd4, 3'd7, 1'b1);
    exp_pkt = exp_pkt + 32'd2;
    check("full_in_ready", in_ready, 1'b0);
    check("full_hold_valid", out_valid, 1'b1);
    check("full_hold_sop", out_sop, 1'b1);
    fork
      send_pkt(32'h302, 32, 5'd5, 3'd7, 1'b1);
      begin
        drain(32'h300, 32, 5'd3, 16'd256, 1'b0, w);
        drain(32'h301, 32, 5'd4, 16'd256, 1'b0, w);
        drain(32'h302, 32, 5'd5, 16'd256, 1'b0, w);
      end
    join
    exp_pkt = exp_pkt + 32'd1;
    check("full_pkt_cnt", pkt_cnt, exp_pkt);

    // stray beat, then sop inside an open packet
    send_beat(1'b0, 1'b0, 3'd0, 5'd9, 64'hDEAD);
    exp_err = exp_err + 16'd1;
    repeat (3) @(negedge clk);
    check("stray_no_record", out_valid, 1'b0);
    check("stray_pkt_cnt", pkt_cnt, exp_pkt);
    check("stray_err_cnt", err_cnt, exp_err);
    send_pkt(32'h400, 3, 5'd2, 3'd0, 1'b0);
    send_pkt(32'h401, 4, 5'd4, 3'd7, 1'b1);
    exp_pkt = exp_pkt + 32'd2;
    exp_err = exp_err + 16'd1;
    check("trunc_pkt_cnt", pkt_cnt, exp_pkt);
    check("trunc_err_cnt", err_cnt, exp_err);
    drain(32'h400, 3, 5'd2, 16'd24, 1'b1, w);
    drain(32'h401, 4, 5'd4, 16'd32, 1'b0, w);

    // reset with a stored record and an open packet
    send_pkt(32'h500, 2, 5'd11, 3'd7, 1'b1);
    send_pkt(32'h501, 4, 5'd12, 3'd7, 1'b0);
    check("pre_rst_valid", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_pkt_cnt", pkt_cnt, 32'd0);
    check("mid_rst_err_cnt", err_cnt, 16'd0);
    check("mid_rst_out_data", out_data, 64'd0);
    check("mid_rst_out_port", out_port, 5'd0);
    check("mid_rst_out_len", out_len, 16'd0);
    check("mid_rst_in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_pkt(32'h600, 2, 5'd6, 3'd7, 1'b1);
    check("post_rst_pkt_cnt", pkt_cnt, 32'd1);
    drain(32'h600, 2, 5'd6, 16'd16, 1'b0, w);
    check("post_rst_empty", out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
